// File: rtl/mcontr_pkg.sv
// Shared definitions for the memory-controller channel client: FSM states and
// default geometry of the channel page buffer.
package mcontr_pkg;

  localparam int PAGE_BITS_DEF     = 8;
  localparam int PAGE_NUM_BITS_DEF = 2;
  localparam int URGENT_THR_DEF    = 3;
  localparam int FRAME_W           = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } chn_state_e;

endpackage

// File: rtl/mcontr_page_cnt.sv
// Page occupancy counter of the channel buffer: write page, read page and the
// number of full pages waiting for the SDRAM side.
module mcontr_page_cnt
  import mcontr_pkg::*;
#(
  parameter int PAGE_NUM_BITS = PAGE_NUM_BITS_DEF
) (
  input  logic                     clk0,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     inc,
  input  logic                     dec,
  output logic [PAGE_NUM_BITS:0]   pending,
  output logic [PAGE_NUM_BITS:0]   pending_nxt,
  output logic [PAGE_NUM_BITS-1:0] wr_page,
  output logic [PAGE_NUM_BITS-1:0] rd_page,
  output logic                     full,
  output logic                     empty
);

  localparam logic [PAGE_NUM_BITS:0] CAPACITY = {1'b1, {PAGE_NUM_BITS{1'b0}}};

  logic [PAGE_NUM_BITS:0]   pending_q, pending_d;
  logic [PAGE_NUM_BITS-1:0] wr_page_q, wr_page_d;
  logic [PAGE_NUM_BITS-1:0] rd_page_q, rd_page_d;

  // The caller never raises inc when full or dec when empty.
  always_comb begin
    pending_d = pending_q;
    wr_page_d = wr_page_q;
    rd_page_d = rd_page_q;
    if (clr) begin
      pending_d = '0;
      wr_page_d = '0;
      rd_page_d = '0;
    end else begin
      if (inc) wr_page_d = wr_page_q + 1'b1;
      if (dec) rd_page_d = rd_page_q + 1'b1;
      if (inc && !dec)      pending_d = pending_q + 1'b1;
      else if (dec && !inc) pending_d = pending_q - 1'b1;
    end
  end

  always_ff @(negedge clk0 or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      wr_page_q <= '0;
      rd_page_q <= '0;
    end else begin
      pending_q <= pending_d;
      wr_page_q <= wr_page_d;
      rd_page_q <= rd_page_d;
    end
  end

  assign pending     = pending_q;
  assign pending_nxt = pending_d;
  assign wr_page     = wr_page_q;
  assign rd_page     = rd_page_q;
  assign full        = (pending_q == CAPACITY);
  assign empty       = (pending_q == '0);

endmodule

// File: rtl/mcontr_chn_client.sv
// Write-side channel client of the SDRAM arbiter: fills buffer pages and requests
// page transfers. Define MCONTR_CHN_URGENT_EN to build the rq_urgent logic.
module mcontr_chn_client
  import mcontr_pkg::*;
#(
  parameter int PAGE_BITS     = PAGE_BITS_DEF,
  parameter int PAGE_NUM_BITS = PAGE_NUM_BITS_DEF,
  parameter int URGENT_THR    = URGENT_THR_DEF
) (
  input  logic                               clk0,
  input  logic                               rst,
  input  logic                               init,
  input  logic                               frame_start,
  input  logic [FRAME_W-1:0]                 frame_pages,
  input  logic                               wr_stb,
  input  logic                               start,
  output logic                               rq,
  output logic                               rq_urgent,
  output logic [PAGE_NUM_BITS+PAGE_BITS-1:0] wr_addr,
  output logic [PAGE_NUM_BITS-1:0]           rd_page,
  output logic [PAGE_NUM_BITS:0]             pending,
  output logic                               overflow,
  output logic                               spurious,
  output logic                               frame_done,
  output logic                               active
);

  chn_state_e state_q, state_d;
  logic [FRAME_W-1:0]       frame_pages_q, frame_pages_d;
  logic [FRAME_W-1:0]       pages_written_q, pages_written_d;
  logic [PAGE_BITS-1:0]     wcnt_q, wcnt_d;
  logic                     overflow_q, overflow_d;
  logic                     spurious_q, spurious_d;
  logic                     rq_q, rq_d;
  logic                     cnt_clr, page_inc, page_dec;
  logic                     in_frame, accept, req_state;
  logic                     buf_full, buf_empty;
  logic [PAGE_NUM_BITS:0]   pending_nxt;
  logic [PAGE_NUM_BITS-1:0] wr_page;

  mcontr_page_cnt #(.PAGE_NUM_BITS(PAGE_NUM_BITS)) u_page_cnt (
    .clk0        (clk0),
    .rst         (rst),
    .clr         (cnt_clr),
    .inc         (page_inc),
    .dec         (page_dec),
    .pending     (pending),
    .pending_nxt (pending_nxt),
    .wr_page     (wr_page),
    .rd_page     (rd_page),
    .full        (buf_full),
    .empty       (buf_empty)
  );

  // Words are only taken while the frame still owes pages.
  assign in_frame = (state_q == ST_RUN) && (pages_written_q != frame_pages_q);
  assign accept   = in_frame && wr_stb && !buf_full;
  assign page_inc = accept && (wcnt_q == '1);
  assign page_dec = start && !buf_empty;

  always_comb begin
    state_d         = state_q;
    frame_pages_d   = frame_pages_q;
    pages_written_d = pages_written_q;
    wcnt_d          = wcnt_q;
    overflow_d      = overflow_q;
    spurious_d      = spurious_q;
    cnt_clr         = 1'b0;
    if (init) begin
      state_d         = ST_IDLE;
      frame_pages_d   = '0;
      pages_written_d = '0;
      wcnt_d          = '0;
      overflow_d      = 1'b0;
      spurious_d      = 1'b0;
      cnt_clr         = 1'b1;
    end else begin
      if (accept)                   wcnt_d          = wcnt_q + 1'b1;
      if (page_inc)                 pages_written_d = pages_written_q + 1'b1;
      if (in_frame && wr_stb && buf_full) overflow_d = 1'b1;
      if (start && buf_empty)       spurious_d      = 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            state_d         = ST_RUN;
            frame_pages_d   = frame_pages;
            pages_written_d = '0;
            wcnt_d          = '0;
            overflow_d      = 1'b0;
            spurious_d      = 1'b0;
            cnt_clr         = 1'b1;
          end
        end
        ST_RUN:   if (pages_written_q == frame_pages_q) state_d = ST_DRAIN;
        ST_DRAIN: if (buf_empty) state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Requests look at next-state occupancy and drop for one cycle after a start.
  assign req_state = (state_d == ST_RUN) || (state_d == ST_DRAIN);
  assign rq_d      = req_state && !start && (pending_nxt != '0);

  always_ff @(negedge clk0 or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      frame_pages_q   <= '0;
      pages_written_q <= '0;
      wcnt_q          <= '0;
      overflow_q      <= 1'b0;
      spurious_q      <= 1'b0;
      rq_q            <= 1'b0;
    end else begin
      state_q         <= state_d;
      frame_pages_q   <= frame_pages_d;
      pages_written_q <= pages_written_d;
      wcnt_q          <= wcnt_d;
      overflow_q      <= overflow_d;
      spurious_q      <= spurious_d;
      rq_q            <= rq_d;
    end
  end

`ifdef MCONTR_CHN_URGENT_EN
  localparam logic [PAGE_NUM_BITS:0] URGENT_LVL = (PAGE_NUM_BITS+1)'(URGENT_THR);

  logic rq_urgent_q, rq_urgent_d;

  assign rq_urgent_d = req_state && !start &&
                       ((pending_nxt >= URGENT_LVL) ||
                        ((state_d == ST_DRAIN) && (pending_nxt != '0)));

  always_ff @(negedge clk0 or posedge rst) begin
    if (rst) rq_urgent_q <= 1'b0;
    else     rq_urgent_q <= rq_urgent_d;
  end

  assign rq_urgent = rq_urgent_q;
`else
  // Urgent path compiled out; URGENT_THR only matters in the urgent build.
  if (URGENT_THR > (1 << PAGE_NUM_BITS)) begin : g_thr_never_fires
  end
  assign rq_urgent = 1'b0;
`endif

  assign rq         = rq_q;
  assign wr_addr    = {wr_page, wcnt_q};
  assign overflow   = overflow_q;
  assign spurious   = spurious_q;
  assign frame_done = (state_q == ST_DONE);
  assign active     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mcontr_chn_client.sv
// Directed self-checking bench for mcontr_chn_client (default geometry 8/2/3).
// Expected rq_urgent follows MCONTR_CHN_URGENT_EN when the bench is compiled.
module tb_mcontr_chn_client;

`ifdef MCONTR_CHN_URGENT_EN
  localparam logic URG = 1'b1;
`else
  localparam logic URG = 1'b0;
`endif

  logic        clk0 = 1'b0;
  logic        rst, init, frame_start, wr_stb, start;
  logic [11:0] frame_pages;
  logic        rq, rq_urgent, overflow, spurious, frame_done, active;
  logic [9:0]  wr_addr;
  logic [1:0]  rd_page;
  logic [2:0]  pending;

  int total    = 0;
  int bad      = 0;
  int done_cnt = 0;
  int done_ref;

  mcontr_chn_client #(.PAGE_BITS(8), .PAGE_NUM_BITS(2), .URGENT_THR(3)) dut (
    .clk0        (clk0),
    .rst         (rst),
    .init        (init),
    .frame_start (frame_start),
    .frame_pages (frame_pages),
    .wr_stb      (wr_stb),
    .start       (start),
    .rq          (rq),
    .rq_urgent   (rq_urgent),
    .wr_addr     (wr_addr),
    .rd_page     (rd_page),
    .pending     (pending),
    .overflow    (overflow),
    .spurious    (spurious),
    .frame_done  (frame_done),
    .active      (active)
  );

  // DUT works on negedge; the bench drives and samples on posedge.
  always #5 clk0 = ~clk0;

  always @(posedge clk0) if (frame_done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic fs, input logic [11:0] fp, input logic ws, input logic st);
    frame_start = fs;
    frame_pages = fp;
    wr_stb      = ws;
    start       = st;
    @(posedge clk0);
    frame_start = 1'b0;
    wr_stb      = 1'b0;
    start       = 1'b0;
  endtask

  task automatic pulseInit();
    init = 1'b1;
    @(posedge clk0);
    init = 1'b0;
  endtask

  initial begin
    rst = 1'b1; init = 1'b0; frame_start = 1'b0; wr_stb = 1'b0; start = 1'b0;
    frame_pages = 12'd0;
    repeat (2) @(posedge clk0);
    checkOutput("rst_flags", {rq, rq_urgent, overflow, spurious, frame_done, active}, 0);
    checkOutput("rst_pending", pending, 0);
    checkOutput("rst_wr_addr", wr_addr, 0);
    rst = 1'b0;
    @(posedge clk0);

    // Two-page frame, start issued 10 cycles after each page completes
    $display("[TB] two-page frame");
    applyStimulus(1'b1, 12'd2, 1'b0, 1'b0);
    checkOutput("a_active", active, 1);
    done_ref = done_cnt;
    for (int i = 1; i <= 524; i++) begin
      applyStimulus(1'b0, 12'd0, (i <= 512), (i == 266) || (i == 522));
      case (i)
        255: begin checkOutput("a255_pending", pending, 0); checkOutput("a255_rq", rq, 0); end
        256: begin
          checkOutput("a256_pending", pending, 1);
          checkOutput("a256_rq", rq, 1);
          checkOutput("a256_wr_addr", wr_addr, 10'h100);
        end
        266: begin
          checkOutput("a266_pending", pending, 0);
          checkOutput("a266_rq", rq, 0);
          checkOutput("a266_rd_page", rd_page, 1);
        end
        511: checkOutput("a511_rq", rq, 0);
        512: begin
          checkOutput("a512_pending", pending, 1);
          checkOutput("a512_rq", rq, 1);
          checkOutput("a512_wr_addr", wr_addr, 10'h200);
        end
        515: begin
          checkOutput("a515_rq", rq, 1);
          checkOutput("a515_rq_urgent", rq_urgent, URG);
          checkOutput("a515_done", frame_done, 0);
        end
        522: begin
          checkOutput("a522_pending", pending, 0);
          checkOutput("a522_rq", {rq, rq_urgent}, 0);
          checkOutput("a522_rd_page", rd_page, 2);
        end
        523: checkOutput("a523_frame_done", frame_done, 1);
        524: checkOutput("a524_idle", {frame_done, active}, 0);
        default: ;
      endcase
    end
    applyStimulus(1'b0, 12'd0, 1'b0, 1'b0);
    checkOutput("a_done_pulses", done_cnt - done_ref, 1);

    // Overflow with no starts, preceded by a spurious start
    $display("[TB] overflow frame");
    applyStimulus(1'b1, 12'd8, 1'b0, 1'b0);
    applyStimulus(1'b0, 12'd0, 1'b0, 1'b1);
    checkOutput("b_spurious", spurious, 1);
    checkOutput("b_rd_page", rd_page, 0);
    checkOutput("b_rq", rq, 0);
    for (int i = 1; i <= 1026; i++) begin
      applyStimulus(1'b0, 12'd0, 1'b1, 1'b0);
      case (i)
        767: begin
          checkOutput("b767_pending", pending, 2);
          checkOutput("b767_rq", rq, 1);
          checkOutput("b767_rq_urgent", rq_urgent, 0);
        end
        768: begin
          checkOutput("b768_pending", pending, 3);
          checkOutput("b768_rq_urgent", rq_urgent, URG);
        end
        1024: begin
          checkOutput("b1024_pending", pending, 4);
          checkOutput("b1024_wr_addr", wr_addr, 10'h000);
          checkOutput("b1024_overflow", overflow, 0);
          checkOutput("b1024_rq_urgent", rq_urgent, URG);
        end
        1025: begin
          checkOutput("b1025_overflow", overflow, 1);
          checkOutput("b1025_wr_addr", wr_addr, 10'h000);
          checkOutput("b1025_pending", pending, 4);
        end
        1026: checkOutput("b1026_spurious_sticky", spurious, 1);
        default: ;
      endcase
    end
    pulseInit();
    checkOutput("init_flags", {rq, rq_urgent, overflow, spurious, frame_done, active}, 0);
    checkOutput("init_pending", pending, 0);
    checkOutput("init_wr_addr", wr_addr, 0);

    // Page completion and start in the same cycle with two pages pending
    $display("[TB] simultaneous completion and start");
    applyStimulus(1'b1, 12'd8, 1'b0, 1'b0);
    for (int i = 1; i <= 767; i++) applyStimulus(1'b0, 12'd0, 1'b1, 1'b0);
    checkOutput("c_pending_before", pending, 2);
    checkOutput("c_wr_addr_before", wr_addr, 10'h2FF);
    applyStimulus(1'b0, 12'd0, 1'b1, 1'b1);
    checkOutput("c_pending_after", pending, 2);
    checkOutput("c_wr_addr_after", wr_addr, 10'h300);
    checkOutput("c_rd_page_after", rd_page, 1);
    checkOutput("c_rq_suppressed", rq, 0);
    applyStimulus(1'b0, 12'd0, 1'b0, 1'b0);
    checkOutput("c_rq_back", rq, 1);

    // Reset while draining, then a zero-page frame
    $display("[TB] reset in drain");
    pulseInit();
    applyStimulus(1'b1, 12'd1, 1'b0, 1'b0);
    for (int i = 1; i <= 256; i++) applyStimulus(1'b0, 12'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 12'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 12'd0, 1'b1, 1'b0);
    checkOutput("d_drain_wr_addr", wr_addr, 10'h100);
    checkOutput("d_drain_overflow", overflow, 0);
    checkOutput("d_drain_pending", pending, 1);
    checkOutput("d_drain_rq", {active, rq, rq_urgent}, {1'b1, 1'b1, URG});
    done_ref = done_cnt;
    rst = 1'b1;
    #1;
    checkOutput("d_rst_flags", {rq, rq_urgent, overflow, spurious, frame_done, active}, 0);
    checkOutput("d_rst_pending", pending, 0);
    checkOutput("d_rst_wr_addr", wr_addr, 0);
    @(posedge clk0);
    rst = 1'b0;
    repeat (3) applyStimulus(1'b0, 12'd0, 1'b0, 1'b0);
    checkOutput("d_no_done", done_cnt - done_ref, 0);
    checkOutput("d_idle", active, 0);

    applyStimulus(1'b1, 12'd0, 1'b0, 1'b0);
    checkOutput("e_run", {active, rq}, 2'b10);
    applyStimulus(1'b1, 12'd5, 1'b0, 1'b0);
    checkOutput("e_drain", {active, rq, frame_done}, 3'b100);
    applyStimulus(1'b0, 12'd0, 1'b0, 1'b0);
    checkOutput("e_done", {frame_done, rq, rq_urgent}, 3'b100);
    applyStimulus(1'b0, 12'd0, 1'b0, 1'b0);
    checkOutput("e_idle", {frame_done, active}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mcontr_chn_client.md
MCONTR_CHN_CLIENT -- requirements
Module: mcontr_chn_client

Interface
REQ-001 Parameter PAGE_BITS, default 8: log2 of words per SDRAM page transfer (256 words).
REQ-002 Parameter PAGE_NUM_BITS, default 2: log2 of pages in the channel buffer (4 pages).
REQ-003 Parameter URGENT_THR, default 3: pending-page count at which rq_urgent asserts.
REQ-004 clk0  in  1  system clock; all logic on negedge clk0, matching the arbiter.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 init  in  1  synchronous channel init, the same function as the arbiter's init_chn bit.
REQ-007 frame_start  in  1  one-cycle pulse that starts a frame.
REQ-008 frame_pages  in  12  pages per frame, sampled on frame_start.
REQ-009 wr_stb  in  1  one client word written to the buffer this cycle.
REQ-010 start  in  1  this channel's bit of the arbiter one-hot start; means one page is being taken.
REQ-011 rq  out  1  low-priority transfer request to the arbiter.
REQ-012 rq_urgent  out  1  high-priority transfer request to the arbiter.
REQ-013 wr_addr  out  PAGE_NUM_BITS+PAGE_BITS  buffer write address {wr_page, wcnt}.
REQ-014 rd_page  out  PAGE_NUM_BITS  buffer page the SDRAM side reads next.
REQ-015 pending  out  PAGE_NUM_BITS+1  full pages not yet started.
REQ-016 overflow  out  1  sticky flag: a word was dropped because the buffer was full.
REQ-017 spurious  out  1  sticky flag: start arrived with pending==0.
REQ-018 frame_done  out  1  one-cycle pulse at frame completion.
REQ-019 active  out  1  high whenever the state is not IDLE.

Function
REQ-020 States SHALL be IDLE, RUN, DRAIN and DONE.
REQ-021 IDLE->RUN on frame_start; frame_pages SHALL be latched and wcnt, wr_page, rd_page, pending, pages_written, overflow and spurious cleared.
REQ-022 In RUN, each accepted wr_stb SHALL increment wcnt modulo 2^PAGE_BITS.
REQ-023 When wcnt wraps 0xFF->0, the completed page SHALL increment pending and pages_written, and wr_page SHALL advance modulo 2^PAGE_NUM_BITS.
REQ-024 RUN->DRAIN in the cycle after pages_written reaches the latched frame_pages; wr_stb in DRAIN, DONE and IDLE SHALL be ignored without setting any flag.
REQ-025 DRAIN->DONE when pending==0; DONE SHALL assert frame_done for one cycle and then return to IDLE.
REQ-026 frame_start outside IDLE SHALL be ignored.
REQ-027 A frame_pages value of 0 SHALL go RUN->DRAIN->DONE with no requests.
REQ-028 wr_stb when pending==2^PAGE_NUM_BITS SHALL drop the word, hold wcnt and set overflow.
REQ-029 start with pending>0 SHALL decrement pending and advance rd_page.
REQ-030 start with pending==0 SHALL set spurious and change no counter.
REQ-031 A page completion and a start in the same cycle SHALL leave pending unchanged while both wr_page and rd_page advance.
REQ-032 rq SHALL be registered: high when next-state pending!=0, and forced low in the cycle after a start.
REQ-033 rq_urgent SHALL be registered and obey the same start suppression: high when next-state pending>=URGENT_THR, or when in DRAIN with pending!=0.
REQ-034 rq and rq_urgent SHALL be low in IDLE and DONE.
REQ-035 init SHALL act like rst one clock later: synchronous return to IDLE with all counters, flags and requests cleared; init has priority over every other input.

Reset
REQ-036 rst SHALL immediately force IDLE, all counters to 0, and rq, rq_urgent, overflow, spurious, frame_done and active to 0.
REQ-037 rst mid-frame SHALL abandon the frame with no frame_done.

Configuration
REQ-038 With macro MCONTR_CHN_URGENT_EN defined, rq_urgent SHALL behave per REQ-033.
REQ-039 Without MCONTR_CHN_URGENT_EN, rq_urgent SHALL be tied to 0 and no threshold logic SHALL be built.

Structure
REQ-040 Package mcontr_pkg SHALL hold the state enumeration, PAGE_BITS, PAGE_NUM_BITS and URGENT_THR defaults, and the frame-count width (12).
REQ-041 One sub-module, mcontr_page_cnt, SHALL hold the pending/wr_page/rd_page occupancy counter with inc, dec, full and empty; the FSM and request registers stay in the top.

Verification
REQ-042 Frame start, frame_pages=2, then 512 consecutive wr_stb with a start 10 cycles after each page completes -> rq rises after word 256 and again after word 512; pending follows 1,0,1,0; frame_done pulses once; final state IDLE.
REQ-043 frame_pages=8, 1024 wr_stb, no start -> pending reaches 3 with rq_urgent=1, then 4; word 1025 dropped; overflow=1; wr_addr holds 0x000.
REQ-044 Page completion and start in the same cycle with pending=2 -> pending stays 2; wr_page and rd_page each advance by 1.
REQ-045 start with pending=0 -> spurious=1; rd_page unchanged; rq stays 0.
REQ-046 rst asserted while in DRAIN with pending=1 -> all outputs 0 immediately; no frame_done; the next frame_start runs normally.
REQ-047 Build without MCONTR_CHN_URGENT_EN and rerun REQ-043 -> rq_urgent constantly 0; rq, pending and overflow behave identically.
